// File: rtl/dc_huffman_pkg.sv
// Shared types and DC Huffman code tables for the JPEG entropy-decode path.
// Codes are right-aligned in KOD_W bits; lengths give the number of valid bits.
package dc_huffman_pkg;

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,
        KOD      = 3'd1,
        BUYUKLUK = 3'd2,
        CIKIS    = 3'd3,
        HATA     = 3'd4
    } durum_t;

    localparam int KAT_SAYISI = 12;
    localparam int KOD_W      = 11;

    localparam logic [3:0] LUMA_MAX_UZ  = 4'd9;
    localparam logic [3:0] KROMA_MAX_UZ = 4'd11;

    localparam logic [KOD_W-1:0] LUMA_KOD [KAT_SAYISI] = '{
        11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6,
        11'd14, 11'd30, 11'd62, 11'd126, 11'd254, 11'd510
    };
    localparam logic [3:0] LUMA_UZ [KAT_SAYISI] = '{
        4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

    localparam logic [KOD_W-1:0] KROMA_KOD [KAT_SAYISI] = '{
        11'd0, 11'd1, 11'd2, 11'd6, 11'd14, 11'd30,
        11'd62, 11'd126, 11'd254, 11'd510, 11'd1022, 11'd2046
    };
    localparam logic [3:0] KROMA_UZ [KAT_SAYISI] = '{
        4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
    };

endpackage

// File: rtl/dc_buyukluk_genislet.sv
// Converts a JPEG category and its magnitude bits into a signed difference.
// A leading 0 in the magnitude marks a negative value (one's-complement style).
module dc_buyukluk_genislet #(
    parameter int MAX_KAT = 11,
    parameter int CIKIS_W = 12
) (
    input  logic [3:0]                 kategori,
    input  logic [MAX_KAT-1:0]         buyukluk,
    output logic signed [CIKIS_W-1:0]  fark
);

    logic [CIKIS_W-1:0] maske;
    logic [CIKIS_W-1:0] deger;
    logic [CIKIS_W-1:0] ust;

    always_comb begin
        maske = (CIKIS_W'(1) << kategori) - CIKIS_W'(1);
        deger = CIKIS_W'(buyukluk) & maske;
        ust   = maske & ~(maske >> 1);
        if (kategori == 4'd0) begin
            fark = '0;
        end else if ((deger & ust) != '0) begin
            fark = deger;
        end else begin
            fark = deger - maske;
        end
    end

endmodule

// File: rtl/dc_huffman_cozucu.sv
// Serial JPEG DC decoder: category code match, magnitude collection,
// difference reconstruction and DC predictor accumulation.
//
// state    | meaning
// BOSTA    | idle, waiting for the first code bit (latches table select)
// KOD      | shifting code bits, matching against the selected table
// BUYUKLUK | collecting category magnitude bits
// CIKIS    | {category, difference, DC} valid, waiting for downstream
// HATA     | invalid code seen, sticky until clear or reset
module dc_huffman_cozucu
    import dc_huffman_pkg::*;
#(
    parameter int MAX_KAT = 11,
    parameter int CIKIS_W = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       temizle_i,
    input  logic                       tablo_sec_i,
    input  logic                       bit_gecerli_i,
    input  logic                       bit_i,
    output logic                       bit_hazir_o,
    output logic [3:0]                 kategori_o,
    output logic signed [CIKIS_W-1:0]  fark_o,
    output logic signed [CIKIS_W-1:0]  dc_o,
    output logic                       cikis_gecerli_o,
    input  logic                       cikis_hazir_i,
    output logic                       hata_o
);

    durum_t              durum_q, durum_d;
    logic                tablo_q;
    logic [KOD_W-1:0]    kod_q;
    logic [3:0]          uz_q;
    logic [3:0]          kat_q;
    logic [3:0]          sayac_q;
    logic [MAX_KAT-1:0]  mag_q;
    logic [CIKIS_W-1:0]  fark_q, dc_q, pred_q;

    logic                kabul;
    logic [KOD_W-1:0]    yeni_kod;
    logic [3:0]          yeni_uz;
    logic [MAX_KAT-1:0]  yeni_mag;
    logic [3:0]          tablo_max;
    logic                eslesme;
    logic [3:0]          eslesen_kat;
    logic                kat_gecerli;
    logic signed [CIKIS_W-1:0] fark_yeni;

    assign bit_hazir_o     = rst_i && (durum_q == BOSTA || durum_q == KOD || durum_q == BUYUKLUK);
    assign kabul           = bit_gecerli_i && bit_hazir_o;
    assign yeni_kod        = {kod_q[KOD_W-2:0], bit_i};
    assign yeni_uz         = uz_q + 4'd1;
    assign yeni_mag        = {mag_q[MAX_KAT-2:0], bit_i};
    assign tablo_max       = tablo_q ? KROMA_MAX_UZ : LUMA_MAX_UZ;
    assign kat_gecerli     = int'(eslesen_kat) <= MAX_KAT;

    assign kategori_o      = kat_q;
    assign fark_o          = fark_q;
    assign dc_o            = dc_q;
    assign cikis_gecerli_o = (durum_q == CIKIS);
    assign hata_o          = (durum_q == HATA);

    // Match on the register plus the bit arriving this cycle; the tables are prefix-free.
    always_comb begin
        eslesme     = 1'b0;
        eslesen_kat = '0;
        for (int k = 0; k < KAT_SAYISI; k++) begin
            if (!tablo_q) begin
                if (LUMA_UZ[k] == yeni_uz && LUMA_KOD[k] == yeni_kod) begin
                    eslesme     = 1'b1;
                    eslesen_kat = 4'(k);
                end
            end else begin
                if (KROMA_UZ[k] == yeni_uz && KROMA_KOD[k] == yeni_kod) begin
                    eslesme     = 1'b1;
                    eslesen_kat = 4'(k);
                end
            end
        end
    end

    dc_buyukluk_genislet #(
        .MAX_KAT (MAX_KAT),
        .CIKIS_W (CIKIS_W)
    ) u_genislet (
        .kategori (kat_q),
        .buyukluk (yeni_mag),
        .fark     (fark_yeni)
    );

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA:    if (kabul) durum_d = KOD;
            KOD: begin
                if (kabul) begin
                    if (eslesme) begin
                        if (eslesen_kat == 4'd0)  durum_d = CIKIS;
                        else if (!kat_gecerli)    durum_d = HATA;
                        else                      durum_d = BUYUKLUK;
                    end else if (yeni_uz >= tablo_max) begin
                        durum_d = HATA;
                    end
                end
            end
            BUYUKLUK: if (kabul && sayac_q == 4'd1) durum_d = CIKIS;
            CIKIS:    if (cikis_hazir_i) durum_d = BOSTA;
            HATA:     durum_d = HATA;
            default:  durum_d = BOSTA;
        endcase
        if (temizle_i) durum_d = BOSTA;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) durum_q <= BOSTA;
        else        durum_q <= durum_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tablo_q <= 1'b0;
            kod_q   <= '0;
            uz_q    <= '0;
            kat_q   <= '0;
            sayac_q <= '0;
            mag_q   <= '0;
            fark_q  <= '0;
            dc_q    <= '0;
            pred_q  <= '0;
        end else if (temizle_i) begin
            kod_q   <= '0;
            uz_q    <= '0;
            kat_q   <= '0;
            sayac_q <= '0;
            mag_q   <= '0;
            fark_q  <= '0;
            dc_q    <= '0;
            pred_q  <= '0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (kabul) begin
                        tablo_q <= tablo_sec_i;
                        kod_q   <= {{(KOD_W-1){1'b0}}, bit_i};
                        uz_q    <= 4'd1;
                        mag_q   <= '0;
                    end
                end
                KOD: begin
                    if (kabul) begin
                        kod_q <= yeni_kod;
                        uz_q  <= yeni_uz;
                        if (eslesme && kat_gecerli) begin
                            kat_q   <= eslesen_kat;
                            sayac_q <= eslesen_kat;
                            if (eslesen_kat == 4'd0) begin
                                fark_q <= '0;
                                dc_q   <= pred_q;
                            end
                        end
                    end
                end
                BUYUKLUK: begin
                    if (kabul) begin
                        mag_q   <= yeni_mag;
                        sayac_q <= sayac_q - 4'd1;
                        if (sayac_q == 4'd1) begin
                            fark_q <= fark_yeni;
                            dc_q   <= pred_q + fark_yeni;
                        end
                    end
                end
                CIKIS: if (cikis_hazir_i) pred_q <= dc_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_huffman_cozucu.sv
// Directed bench for the DC Huffman decoder with hand-computed expected triples.
module tb_dc_huffman_cozucu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        temizle_i;
    logic        tablo_sec_i;
    logic        bit_gecerli_i;
    logic        bit_i;
    logic        bit_hazir_o;
    logic [3:0]  kategori_o;
    logic [11:0] fark_o;
    logic [11:0] dc_o;
    logic        cikis_gecerli_o;
    logic        cikis_hazir_i;
    logic        hata_o;

    int toplam = 0;
    int hatali = 0;

    dc_huffman_cozucu #(.MAX_KAT(11), .CIKIS_W(12)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .temizle_i       (temizle_i),
        .tablo_sec_i     (tablo_sec_i),
        .bit_gecerli_i   (bit_gecerli_i),
        .bit_i           (bit_i),
        .bit_hazir_o     (bit_hazir_o),
        .kategori_o      (kategori_o),
        .fark_o          (fark_o),
        .dc_o            (dc_o),
        .cikis_gecerli_o (cikis_gecerli_o),
        .cikis_hazir_i   (cikis_hazir_i),
        .hata_o          (hata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // Send one bit; t drives tablo_sec_i; bosluk idle cycles precede it.
    task automatic bit_gonder(input logic b, input logic t, input int bosluk);
        int n;
        repeat (bosluk) begin
            @(posedge clk_i);
            #1;
        end
        bit_gecerli_i = 1'b1;
        bit_i         = b;
        tablo_sec_i   = t;
        n = 0;
        while (!bit_hazir_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 50) kontrol("hazir_bekleme", 32'(bit_hazir_o), 32'(1));
        @(posedge clk_i);
        #1;
        bit_gecerli_i = 1'b0;
    endtask

    // MSB-first: bits[n-1] goes first. The first bit carries table t0, the rest t1.
    task automatic kod_gonder(input logic [15:0] bits, input int n, input logic t0, input logic t1, input int maxgap);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) begin
            bit_gonder(v[i], (i == n - 1) ? t0 : t1, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic el_sikis();
        cikis_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        cikis_hazir_i = 1'b0;
    endtask

    task automatic uclu_kontrol(input string etiket, input logic [3:0] k, input logic [11:0] f, input logic [11:0] d);
        kontrol({etiket, "_gecerli"}, 32'(cikis_gecerli_o), 32'(1));
        kontrol({etiket, "_kat"}, 32'(kategori_o), 32'(k));
        kontrol({etiket, "_fark"}, 32'(fark_o), 32'(f));
        kontrol({etiket, "_dc"}, 32'(dc_o), 32'(d));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b0;
        temizle_i     = 1'b0;
        tablo_sec_i   = 1'b0;
        bit_gecerli_i = 1'b0;
        bit_i         = 1'b0;
        cikis_hazir_i = 1'b0;

        #12;
        kontrol("rst_hazir", 32'(bit_hazir_o), 32'(0));
        kontrol("rst_gecerli", 32'(cikis_gecerli_o), 32'(0));
        kontrol("rst_hata", 32'(hata_o), 32'(0));
        kontrol("rst_dc", 32'(dc_o), 32'(0));
        kontrol("rst_kat", 32'(kategori_o), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        kontrol("rst_sonrasi_hazir", 32'(bit_hazir_o), 32'(1));

        // luma 011 + 10: cat 2, +2
        kod_gonder(16'b01110, 5, 1'b0, 1'b0, 0);
        uclu_kontrol("l_kat2", 4'd2, 12'h002, 12'h002);
        kontrol("l_kat2_hazir", 32'(bit_hazir_o), 32'(0));
        el_sikis();
        kontrol("l_kat2_dusus", 32'(cikis_gecerli_o), 32'(0));

        // luma 100 + 010: cat 3, 2-7=-5, dc=2-5=-3; then stall 5 cycles
        kod_gonder(16'b100010, 6, 1'b0, 1'b0, 0);
        uclu_kontrol("l_kat3", 4'd3, 12'hffb, 12'hffd);
        bit_gecerli_i = 1'b1;
        bit_i         = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            #1;
            kontrol("bekle_gecerli", 32'(cikis_gecerli_o), 32'(1));
            kontrol("bekle_fark", 32'(fark_o), 32'(12'hffb));
            kontrol("bekle_dc", 32'(dc_o), 32'(12'hffd));
            kontrol("bekle_hazir", 32'(bit_hazir_o), 32'(0));
        end
        bit_gecerli_i = 1'b0;
        el_sikis();
        kontrol("bekle_sonra_hazir", 32'(bit_hazir_o), 32'(1));

        // luma 00: cat 0, dc stays -3
        kod_gonder(16'b00, 2, 1'b0, 1'b0, 0);
        uclu_kontrol("l_kat0", 4'd0, 12'h000, 12'hffd);
        el_sikis();

        // chroma 01 + 0: cat 1, -1, dc=-4
        kod_gonder(16'b010, 3, 1'b1, 1'b1, 0);
        uclu_kontrol("c_kat1", 4'd1, 12'hfff, 12'hffc);
        el_sikis();

        // chroma 11111111110 + 11 ones: cat 11, +2047, dc=-4+2047=2043
        kod_gonder(16'b11111111110, 11, 1'b1, 1'b1, 0);
        kod_gonder(16'b11111111111, 11, 1'b1, 1'b1, 0);
        uclu_kontrol("c_kat11", 4'd11, 12'h7ff, 12'h7fb);
        el_sikis();

        // luma nine ones: invalid code
        kod_gonder(16'b111111111, 9, 1'b0, 1'b0, 0);
        kontrol("hata_bayrak", 32'(hata_o), 32'(1));
        kontrol("hata_hazir", 32'(bit_hazir_o), 32'(0));
        repeat (3) @(posedge clk_i);
        #1;
        kontrol("hata_yapiskan", 32'(hata_o), 32'(1));
        temizle_i = 1'b1;
        @(posedge clk_i);
        #1;
        temizle_i = 1'b0;
        kontrol("temizle_hata", 32'(hata_o), 32'(0));
        kontrol("temizle_hazir", 32'(bit_hazir_o), 32'(1));

        // predictor cleared: luma 011 10 gives dc=2
        kod_gonder(16'b01110, 5, 1'b0, 1'b0, 0);
        uclu_kontrol("temizle_pred", 4'd2, 12'h002, 12'h002);
        el_sikis();

        // luma 100 010 with gaps and table toggled after the first bit: same as luma, dc=2-5=-3
        kod_gonder(16'b100010, 6, 1'b0, 1'b1, 3);
        uclu_kontrol("bosluklu", 4'd3, 12'hffb, 12'hffd);
        el_sikis();

        // reset in the middle of the magnitude bits
        kod_gonder(16'b0111, 4, 1'b0, 1'b0, 0);
        #2;
        rst_i = 1'b0;
        #1;
        kontrol("ara_rst_gecerli", 32'(cikis_gecerli_o), 32'(0));
        kontrol("ara_rst_kat", 32'(kategori_o), 32'(0));
        kontrol("ara_rst_fark", 32'(fark_o), 32'(0));
        kontrol("ara_rst_dc", 32'(dc_o), 32'(0));
        kontrol("ara_rst_hazir", 32'(bit_hazir_o), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        kod_gonder(16'b00, 2, 1'b0, 1'b0, 0);
        uclu_kontrol("rst_sonra_kat0", 4'd0, 12'h000, 12'h000);
        el_sikis();

        // luma 010 + 1: cat 1, +1, dc=1; clear coincident with handshake
        kod_gonder(16'b0101, 4, 1'b0, 1'b0, 0);
        uclu_kontrol("l_kat1", 4'd1, 12'h001, 12'h001);
        temizle_i     = 1'b1;
        cikis_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        temizle_i     = 1'b0;
        cikis_hazir_i = 1'b0;
        kontrol("temizle_el_gecerli", 32'(cikis_gecerli_o), 32'(0));
        kontrol("temizle_el_kat", 32'(kategori_o), 32'(0));
        kontrol("temizle_el_fark", 32'(fark_o), 32'(0));
        kontrol("temizle_el_dc", 32'(dc_o), 32'(0));

        // luma 011 + 11: cat 2, +3, dc=3 (predictor not updated by the cleared handshake)
        kod_gonder(16'b01111, 5, 1'b0, 1'b0, 0);
        uclu_kontrol("son_kat2", 4'd2, 12'h003, 12'h003);
        el_sikis();

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule

// File: doc/dc_huffman_cozucu.md
Name: dc_huffman_cozucu

Overview:
- Serial JPEG DC-coefficient decoder for the entropy-decode path.
- Consumes one bitstream bit per accepted cycle and matches the DC Huffman category code against the luminance or chrominance table, selected at run time.
- Collects the category's magnitude bits, reconstructs the signed DC difference, and accumulates it into a DC predictor.
- Presents {category, difference, DC value} on a valid/ready output handshake; feeds the downstream AC/IDCT stage.

Parameters:
- MAX_KAT, 11: highest legal category; a decoded category above it is an error.
- CIKIS_W, 12: width of signed difference and predictor outputs; must be >= MAX_KAT+1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- temizle_i  in  1  synchronous restart-marker clear: predictor, FSM and error flag return to reset values.
- tablo_sec_i  in  1  0 = luminance DC table, 1 = chrominance DC table; sampled with the first code bit.
- bit_gecerli_i  in  1  bit_i is valid this cycle.
- bit_i  in  1  serial bitstream bit, MSB-first.
- bit_hazir_o  out  1  block accepts a bit this cycle.
- kategori_o  out  4  decoded category, 0..MAX_KAT.
- fark_o  out  CIKIS_W  signed DC difference.
- dc_o  out  CIKIS_W  signed predictor + difference (wraps mod 2^CIKIS_W).
- cikis_gecerli_o  out  1  output triple valid.
- cikis_hazir_i  in  1  downstream accepts the triple.
- hata_o  out  1  sticky: invalid code or category > MAX_KAT.

Behaviour:
- Reset (rst_i=0, async):
  - FSM returns to BOSTA; predictor, kategori_o, fark_o, dc_o, cikis_gecerli_o and hata_o go to 0.
  - bit_hazir_o is 0 while reset is asserted and 1 in the first cycle after release.
- A bit is accepted when bit_gecerli_i && bit_hazir_o. bit_hazir_o=1 only in BOSTA, KOD and BUYUKLUK.
- BOSTA: an accepted bit latches tablo_sec_i, loads the code shift register with that bit (length 1), and moves to KOD.
- KOD: each accepted bit shifts into the code register (LSB side) and increments the length.
  - Luminance codes: cat 0 = 00, 1 = 010, 2 = 011, 3 = 100, 4 = 101, 5 = 110, 6 = 1110, 7 = 11110, 8 = 111110, 9 = 1111110, 10 = 11111110, 11 = 111111110.
  - Chrominance codes: cat 0 = 00, 1 = 01, 2 = 10, 3 = 110, 4 = 1110, 5 = 11110, 6 = 111110, 7 = 1111110, 8 = 11111110, 9 = 111111110, 10 = 1111111110, 11 = 11111111110.
  - Match is evaluated on {register, incoming bit} in the same cycle that bit is accepted.
  - On a match with cat=0: go to CIKIS; fark=0.
  - On a match with 0 < cat <= MAX_KAT: go to BUYUKLUK; magnitude counter = cat.
  - On a match with cat > MAX_KAT, or the length reaching the table maximum (9 luminance / 11 chrominance) with no match: go to HATA.
- BUYUKLUK: each accepted bit shifts into the magnitude register and decrements the counter. On the last bit:
  - if the first magnitude bit = 1, fark = magnitude;
  - otherwise fark = magnitude - (2^cat - 1).
  - Sign-extend to CIKIS_W, then go to CIKIS.
- CIKIS:
  - cikis_gecerli_o=1 starting the cycle after the final bit is accepted (latency 1 cycle from last bit).
  - kategori_o, fark_o and dc_o = pred+fark are stable while valid.
  - On cikis_gecerli_o && cikis_hazir_i: pred <= pred+fark (wraps); go to BOSTA; cikis_gecerli_o drops the next cycle.
  - No bit is accepted during the handshake cycle.
- HATA: hata_o=1, bit_hazir_o=0. Stays in HATA until temizle_i or reset; the predictor is unchanged.
- temizle_i has priority over every other event in the same cycle, including a handshake or a bit acceptance. Effects: pred=0, FSM to BOSTA, hata_o=0, cikis_gecerli_o=0, and any partially received code is discarded.
- bit_gecerli_i gaps of any length are allowed in KOD/BUYUKLUK; state is held.
- tablo_sec_i changes after the first code bit are ignored until the next symbol.
- Illegal FSM encodings recover to BOSTA.

Decomposition:
- Shared package dc_huffman_pkg:
  - FSM state enum (BOSTA, KOD, BUYUKLUK, CIKIS, HATA);
  - both DC code tables as constant code/length arrays indexed by category;
  - max code lengths (9, 11).
- One sub-module: dc_buyukluk_genislet. It is combinational and converts (category, magnitude bits) to a signed CIKIS_W difference; reused by the AC decoder.

Test Plan:
- Luminance bits 011 10 (cat 2, mag 10b) -> kategori_o=2, fark_o=+2, dc_o=2 one cycle after the last bit; after the handshake pred=2.
- Continue with luminance 100 010 (cat 3, mag 010b) -> fark_o=2-7=-5, dc_o=-3; then 00 -> kategori_o=0, fark_o=0, dc_o=-3.
- Chrominance 01 0 (cat 1, mag 0) -> fark_o=-1; chrominance 11111111110 + 11 bits all 1 -> kategori_o=11, fark_o=+2047.
- Luminance 111111111 (9 ones) -> hata_o=1, bit_hazir_o=0; temizle_i pulse -> hata_o=0, pred=0, bit_hazir_o=1.
- Hold cikis_hazir_i=0 for 5 cycles with valid=1 -> outputs stable, bit_hazir_o=0, no bit consumed; random bit_gecerli_i gaps during KOD give identical results.
- Assert rst_i low mid-BUYUKLUK and temizle_i coincident with a handshake -> all outputs 0, pred not updated, next symbol decodes from BOSTA.
